mod_alu_addsub_pipe: RTL

//  Parametrised, pipelined add/subtract unit; successor to the 2:1 sum/subtract select stage of the ALU.

---
 rtl/mod_alu_pkg.sv | 34 +++
 rtl/mod_addsub_core.sv | 43 ++++
 rtl/mod_alu_addsub_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mod_alu_pkg.sv
// Shared op encodings, flag bit positions and carry-in selection for the
// pipelined add/subtract unit.
package mod_alu_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned FLAGS_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_ADC = 2'b10;
    localparam logic [OP_W-1:0] OP_SBB = 2'b11;

    localparam int unsigned FLG_C = 0;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_N = 3;

    // Subtract ops feed ~B into the adder.
    function automatic logic op_is_sub(input logic [OP_W-1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry-in: fixed for ADD/SUB, the stored carry for ADC/SBB.
    function automatic logic op_cin(input logic [OP_W-1:0] op, input logic c_reg);
        logic cin;
        case (op)
            OP_ADD:  cin = 1'b0;
            OP_SUB:  cin = 1'b1;
            default: cin = c_reg;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/mod_addsub_core.sv
// Combinational WIDTH-bit add/subtract datapath with N/Z/V/C generation.
// ADDSUB_SAT_EN adds signed saturation on overflow (sat_i).
module mod_addsub_core
    import mod_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             cin_reg_i,
`ifdef ADDSUB_SAT_EN
    input  logic             sat_i,
`endif
    output logic [WIDTH-1:0] y_o,
    output logic             n_o,
    output logic             z_o,
    output logic             v_o,
    output logic             c_o
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] b_eff;
    logic [SUM_W-1:0] sum;

    always_comb begin
        b_eff = op_is_sub(op_i) ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + SUM_W'(op_cin(op_i, cin_reg_i));
        c_o   = sum[WIDTH];
        v_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
        y_o   = sum[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
        // Clamp toward the sign of A; C is deliberately left as the raw carry.
        if (sat_i && v_o) begin
            y_o = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        z_o = (y_o == '0);
        n_o = y_o[WIDTH-1];
    end

endmodule

// File: rtl/mod_alu_addsub_pipe.sv
// Two-stage valid/ready add/subtract pipe with a stored carry for ADC/SBB chains.
// ADDSUB_SAT_EN adds the sat_i port, carried alongside the operands.
module mod_alu_addsub_pipe
    import mod_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               carry_clr_i,
`ifdef ADDSUB_SAT_EN
    input  logic               sat_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   y_o,
    output logic [FLAGS_W-1:0] flags_o
);

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [OP_W-1:0]    s1_op_q, s1_op_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               c_reg_q, c_reg_d;
`ifdef ADDSUB_SAT_EN
    logic               s1_sat_q, s1_sat_d;
`endif

    logic               adv2;
    logic               in_ready;
    logic [WIDTH-1:0]   core_y;
    logic               core_n, core_z, core_v, core_c;

    mod_addsub_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .op_i      (s1_op_q),
        .cin_reg_i (c_reg_q),
`ifdef ADDSUB_SAT_EN
        .sat_i     (s1_sat_q),
`endif
        .y_o       (core_y),
        .n_o       (core_n),
        .z_o       (core_z),
        .v_o       (core_v),
        .c_o       (core_c)
    );

    // Handshake and next-state for both stages and the carry register.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        flags_d     = flags_q;
        c_reg_d     = c_reg_q;
`ifdef ADDSUB_SAT_EN
        s1_sat_d    = s1_sat_q;
`endif

        adv2     = !out_valid_q || out_ready_i;
        in_ready = !s1_valid_q || adv2;

        if (in_ready) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_a_d  = a_i;
                s1_b_d  = b_i;
                s1_op_d = op_i;
`ifdef ADDSUB_SAT_EN
                s1_sat_d = sat_i;
`endif
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d            = core_y;
                flags_d[FLG_N] = core_n;
                flags_d[FLG_Z] = core_z;
                flags_d[FLG_V] = core_v;
                flags_d[FLG_C] = core_c;
                c_reg_d        = core_c;
            end
        end

        // Clear overrides the load; the op computing now already saw the old carry.
        if (carry_clr_i) begin
            c_reg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
            c_reg_q     <= 1'b0;
`ifdef ADDSUB_SAT_EN
            s1_sat_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            c_reg_q     <= c_reg_d;
`ifdef ADDSUB_SAT_EN
            s1_sat_q    <= s1_sat_d;
`endif
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign y_o         = y_q;
    assign flags_o     = flags_q;

endmodule
